// File: rtl/clint_timer_if.sv
// Valid/ready memory-mapped bus between the LSU/AXI bridge and the CLINT.
// The master drives requests and accepts responses. The slave does the reverse.
interface clint_timer_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: holds mtime, mtimecmp and msip behind a
// single-outstanding valid/ready slave port and raises the machine timer and
// software interrupt requests that feed the CSR block.
module clint_timer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h0200_0000,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  clint_timer_if.slave  bus,
  output logic          clint_mtip,
  output logic          clint_msip
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [63:0] OFF_MSIP     = 64'h0000;
  localparam logic [63:0] OFF_MTIMECMP = 64'h4000;
  localparam logic [63:0] OFF_MTIME    = 64'hBFF8;
  localparam logic [7:0]  PRESC_LAST   = 8'(TICK_DIV - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mtime;
  logic [DATA_WIDTH-1:0]   mtimecmp;
  logic                    msip;
  logic [7:0]              presc;

  logic [63:0]             offset;
  logic                    sel_msip;
  logic                    sel_cmp;
  logic                    sel_mtime;
  logic                    err;
  logic                    accept;
  logic                    wr;
  logic                    tick;
  logic [DATA_WIDTH-1:0]   mtime_next;
  logic [DATA_WIDTH-1:0]   mtimecmp_next;
  logic                    msip_next;
  logic [7:0]              presc_next;
  logic [DATA_WIDTH-1:0]   rdata_next;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0]   old,
    input logic [DATA_WIDTH-1:0]   data,
    input logic [DATA_WIDTH/8-1:0] mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old;
    for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
      if (mask[i]) res[i*8 +: 8] = data[i*8 +: 8];
    end
    return res;
  endfunction

  // Address decode, acceptance and next-state values for the timer registers.
  always_comb begin
    offset    = bus.req_addr - BASE_ADDR;
    sel_msip  = (bus.req_addr[2:0] == 3'b000) && (offset == OFF_MSIP);
    sel_cmp   = (bus.req_addr[2:0] == 3'b000) && (offset == OFF_MTIMECMP);
    sel_mtime = (bus.req_addr[2:0] == 3'b000) && (offset == OFF_MTIME);
    err       = !(sel_msip || sel_cmp || sel_mtime);
    accept    = (state == IDLE) && bus.req_valid;
    wr        = accept && bus.req_wen && !err;
    tick      = (presc == PRESC_LAST);

    mtime_next    = tick ? mtime + 1'b1 : mtime;
    presc_next    = tick ? '0 : presc + 8'd1;
    mtimecmp_next = mtimecmp;
    msip_next     = msip;

    // A software write wins over the tick: unmasked bytes keep the
    // pre-increment value and the prescaler restarts its period.
    if (wr && sel_mtime && (bus.req_wmask != '0)) begin
      mtime_next = merge(mtime, bus.req_wdata, bus.req_wmask);
      presc_next = '0;
    end
    if (wr && sel_cmp) mtimecmp_next = merge(mtimecmp, bus.req_wdata, bus.req_wmask);
    if (wr && sel_msip && bus.req_wmask[0]) msip_next = bus.req_wdata[0];

    rdata_next = '0;
    if (!err && !bus.req_wen) begin
      if (sel_msip)       rdata_next = {{(DATA_WIDTH-1){1'b0}}, msip};
      else if (sel_cmp)   rdata_next = mtimecmp;
      else                rdata_next = mtime;
    end
  end

  // Timer registers and registered interrupt outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      presc      <= '0;
      clint_mtip <= 1'b0;
      clint_msip <= 1'b0;
    end else begin
      mtime      <= mtime_next;
      mtimecmp   <= mtimecmp_next;
      msip       <= msip_next;
      presc      <= presc_next;
      clint_mtip <= (mtime_next >= mtimecmp_next);
      clint_msip <= msip_next;
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= RESP;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= rdata_next;
            bus.resp_err   <= err;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance with TICK_DIV = 1 and one with
// TICK_DIV = 4, sharing clock and reset.
module tb_clint_timer;

  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] A_MSIP = BASE + 64'h0000;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_MTIME = BASE + 64'hBFF8;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst_n;
  logic clint_mtip, clint_msip;
  logic mtip4, msip4;

  clint_timer_if bus ();
  clint_timer_if bus4 ();

  clint_timer #(.DATA_WIDTH(64), .BASE_ADDR(BASE), .TICK_DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .clint_mtip(clint_mtip), .clint_msip(clint_msip)
  );

  clint_timer #(.DATA_WIDTH(64), .BASE_ADDR(BASE), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .clint_mtip(mtip4), .clint_msip(msip4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges seen since reset release; at a negedge this equals mtime for TICK_DIV = 1.
  longint unsigned cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        mtip_resp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit d4, input logic v, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask);
    if (d4) begin
      bus4.req_valid = v; bus4.req_wen = wen; bus4.req_addr = addr;
      bus4.req_wdata = wdata; bus4.req_wmask = wmask;
    end else begin
      bus.req_valid = v; bus.req_wen = wen; bus.req_addr = addr;
      bus.req_wdata = wdata; bus.req_wmask = wmask;
    end
  endtask

  function automatic logic ready(input bit d4);
    return d4 ? bus4.req_ready : bus.req_ready;
  endfunction

  function automatic logic valid(input bit d4);
    return d4 ? bus4.resp_valid : bus.resp_valid;
  endfunction

  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic xfer(input bit d4, input logic wen, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask,
                      output logic [63:0] rdata, output logic err, output longint unsigned acc);
    int unsigned guard;
    guard = 0;
    drive(d4, 1'b1, wen, addr, wdata, wmask);
    while (!ready(d4) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_idle", 64'(ready(d4)), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    drive(d4, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("resp_latency", 64'(valid(d4)), 64'd1);
    rdata = d4 ? bus4.resp_rdata : bus.resp_rdata;
    err   = d4 ? bus4.resp_err : bus.resp_err;
    mtip_resp = clint_mtip;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_until(input longint unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic er;
    longint unsigned acc, cw;
    logic seen;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    bus.resp_ready = 1'b1;
    bus4.resp_ready = 1'b1;

    @(negedge clk);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", bus.resp_rdata, 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_mtip", 64'(clint_mtip), 64'd0);
    check("rst_msip", 64'(clint_msip), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 10 cycles, then read mtime.
    seen = 1'b0;
    while (cyc < 10) begin
      @(negedge clk);
      if (clint_mtip) seen = 1'b1;
    end
    xfer(1'b0, 1'b0, A_MTIME, '0, '0, rd, er, acc);
    check("mtime_after_10", rd, 64'd10);
    check("mtime_err", 64'(er), 64'd0);
    check("mtip_idle", 64'(seen), 64'd0);

    // mtimecmp = 20: mtip follows mtime >= 20.
    xfer(1'b0, 1'b1, A_CMP, 64'd20, 8'hFF, rd, er, acc);
    check("write_rdata_zero", rd, 64'd0);
    wait_until(19);
    check("mtip_at_19", 64'(clint_mtip), 64'd0);
    @(negedge clk);
    check("mtip_at_20", 64'(clint_mtip), 64'd1);
    xfer(1'b0, 1'b1, A_CMP, ONES, 8'hFF, rd, er, acc);
    check("mtip_ack", 64'(mtip_resp), 64'd0);

    // Zero-mask write is a no-op; mtime keeps counting.
    xfer(1'b0, 1'b1, A_MTIME, 64'd0, 8'h00, rd, er, acc);
    check("wmask0_err", 64'(er), 64'd0);
    xfer(1'b0, 1'b0, A_MTIME, '0, '0, rd, er, acc);
    check("mtime_counting", rd, 64'(acc));

    // msip: only bit 0 sticks.
    xfer(1'b0, 1'b1, A_MSIP, ONES, 8'hFF, rd, er, acc);
    check("clint_msip_set", 64'(clint_msip), 64'd1);
    xfer(1'b0, 1'b0, A_MSIP, '0, '0, rd, er, acc);
    check("msip_read", rd, 64'd1);
    xfer(1'b0, 1'b1, A_MSIP, 64'd0, 8'h00, rd, er, acc);
    xfer(1'b0, 1'b0, A_MSIP, '0, '0, rd, er, acc);
    check("msip_wmask0", rd, 64'd1);

    // Byte-masked mtimecmp write.
    xfer(1'b0, 1'b1, A_CMP, 64'h0000_0000_0000_00AB, 8'h01, rd, er, acc);
    xfer(1'b0, 1'b0, A_CMP, '0, '0, rd, er, acc);
    check("cmp_partial", rd, 64'hFFFF_FFFF_FFFF_FFAB);

    // Unmapped and misaligned addresses.
    xfer(1'b0, 1'b0, BASE + 64'h8, '0, '0, rd, er, acc);
    check("err_unmapped", 64'(er), 64'd1);
    check("err_unmapped_rdata", rd, 64'd0);
    xfer(1'b0, 1'b0, BASE + 64'h4004, '0, '0, rd, er, acc);
    check("err_misaligned", 64'(er), 64'd1);
    check("err_misaligned_rdata", rd, 64'd0);
    xfer(1'b0, 1'b0, 64'h0, '0, '0, rd, er, acc);
    check("err_below_base", 64'(er), 64'd1);
    xfer(1'b0, 1'b1, BASE + 64'h4004, 64'd0, 8'hFF, rd, er, acc);
    check("err_write", 64'(er), 64'd1);
    xfer(1'b0, 1'b0, A_CMP, '0, '0, rd, er, acc);
    check("err_no_change", rd, 64'hFFFF_FFFF_FFFF_FFAB);

    // mtime wrap with mtimecmp = 5.
    xfer(1'b0, 1'b1, A_CMP, 64'd5, 8'hFF, rd, er, acc);
    xfer(1'b0, 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, cw);
    check("mtip_before_wrap", 64'(clint_mtip), 64'd1);
    @(negedge clk);
    check("mtip_after_wrap", 64'(clint_mtip), 64'd0);
    wait_until(cw + 4);
    xfer(1'b0, 1'b0, A_MTIME, '0, '0, rd, er, acc);
    check("mtime_wrapped", rd, 64'd1);

    // TICK_DIV = 4 instance.
    xfer(1'b1, 1'b0, A_MTIME, '0, '0, rd, er, acc);
    check("div4_mtime", rd, 64'(acc / 4));
    while (cyc % 4 != 3) @(negedge clk);
    xfer(1'b1, 1'b1, A_MTIME, 64'd100, 8'hFF, rd, er, cw);
    wait_until(cw + 4);
    xfer(1'b1, 1'b0, A_MTIME, '0, '0, rd, er, acc);
    check("div4_write_on_tick", rd, 64'd100);
    wait_until(cw + 8);
    xfer(1'b1, 1'b0, A_MTIME, '0, '0, rd, er, acc);
    check("div4_first_inc", rd, 64'd101);
    xfer(1'b1, 1'b0, A_MTIME, '0, '0, rd, er, acc);
    check("div4_second_inc", rd, 64'd102);

    // Response held while resp_ready is low.
    bus.resp_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, A_CMP, '0, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.resp_valid), 64'd1);
      check("stall_rdata", bus.resp_rdata, 64'd5);
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_release", 64'(bus.resp_valid), 64'd0);

    // Asynchronous reset in the middle of a response.
    bus.resp_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, A_CMP, '0, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("pre_reset_valid", 64'(bus.resp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.resp_valid), 64'd0);
    check("async_rst_rdata", bus.resp_rdata, 64'd0);
    check("async_rst_mtip", 64'(clint_mtip), 64'd0);
    check("async_rst_msip", 64'(clint_msip), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
